qtr_scan_ctrl: RTL and testbench
================================

Name: qtr_scan_ctrl

Overview:
Scan controller that time-shares one charge/sense timer across four Pololu QTR-RC quad sensors (16 pins total) on the peripheral bus. On each poll tick it charges and senses each enabled bank in turn, one bank at a time, so bank discharges never overlap. It latches a 16-bit black/white map and autosends two bytes to the host. It replaces four independent quad-sensor instances with one bus slot.

Parameters:
NBANK, 4, number of 4-pin sensor banks; fixed at 4 (register map assumes 4).
CHG_TICKS, 1, number of u10clk periods the bank is driven high during CHARGE.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rdwr  in  1  bus direction, 1=read 0=write
strobe  in  1  valid bus command
our_addr  in  4  assigned high address nibble
addr  in  12  target address
busy_in  in  1  upstream busy
busy_out  out  1  =busy_in (pass-through)
addr_match_in  in  1  upstream address claim
addr_match_out  out  1  myaddr | addr_match_in
datin  in  8  bus data in
datout  out  8  bus data out; =datin when not addressed
m10clk  in  1  one-clk pulse every 10 ms
u10clk  in  1  one-clk pulse every 10 us
q  inout  16  QTR pins; bank b = q[4b+3:4b]

Behaviour:
- Reset (async): state=IDLE; q all Z; polltime=0, sens=1, mask=4'hF, result=0, data_avail=0, pollcount=1, bank=0.
- Bus: myaddr = addr[11:8]==our_addr && addr[7:3]==0. Registers:
  - 0: R, {bank1,bank0} result.
  - 1: R, {bank3,bank2} result.
  - 2: R/W, sensitivity (10 us units).
  - 3: R/W, polltime[3:0] (10 ms units; 0=off).
  - 4: R/W, bank enable mask[3:0].
  - Reads of 5-7 return 0; writes to 0, 1, 5-7 are ignored.
  - Writes take effect the clk after strobe.
- Autosend: datout=8'h02 when myaddr && ~strobe && data_avail. Any read strobe clears data_avail. A read in the same clk as data_avail being set: the set wins.
- FSM states: IDLE, CHARGE, SENSE, ADVANCE.
  - IDLE: on m10clk with polltime!=0, pollcount counts to polltime, then restarts at 1. At match, if mask!=0: latch scan_mask=mask, bank=lowest set bit, go to CHARGE. If mask==0: stay IDLE, no autosend.
  - CHARGE: drive selected bank's 4 pins 1; all other pins Z. After CHG_TICKS u10clk pulses, go to SENSE, senscount=1.
  - SENSE: all pins Z. On each u10clk: if senscount==sens (sens 0 is treated as 1), capture bank's 4 pins into a shadow register and go to ADVANCE; else increment senscount.
  - ADVANCE (1 clk): if a higher set bit exists in scan_mask, select it and go to CHARGE. Otherwise copy the shadow into result (only enabled banks update; disabled banks hold their value), set data_avail, go to IDLE.
- m10clk outside IDLE is ignored; pollcount is frozen during a scan.
- mask, sens or polltime writes during a scan do not affect the current scan's bank order. A sens write mid-SENSE is used from the next compare.
- At most one bank is driven at any time; q is Z in every state except CHARGE.
- Worst-case scan: 4·(CHG_TICKS+256)·10 us ≈ 10.3 ms, which can exceed one poll tick. Polls missed while scanning are dropped, not queued.

Optional Feature:
QTR_CHGDET_EN
- Defined: at end of scan, data_avail is set only if the new 16-bit result differs from the previous result; result is still updated.
- Undefined: data_avail is set at the end of every completed scan.

Decomposition:
- Package qtr_pkg holds:
  - state encodings (IDLE=0, CHARGE=1, SENSE=2, ADVANCE=3);
  - register offsets (REG_RES_LO=0, REG_RES_HI=1, REG_SENS=2, REG_POLL=3, REG_MASK=4);
  - autosend length constant 8'h02.
- Sub-module qtr_bank_sel: combinational next-enabled-bank finder. Inputs: scan_mask and current bank. Outputs: next bank and a none-left flag.

Test Plan:
- polltime=1, sens=3, mask=F, banks tied 0x1,0x2,0x4,0x8 (weak pull): after one m10clk, each bank is charged for 1 u10clk then sampled at the 3rd u10clk, in order 0,1,2,3. Reg0 reads 0x21, reg1 reads 0x84; autosend 0x02 seen before the read; data_avail clears after the read.
- mask=4'b0101: only banks 0 and 2 are ever driven; a monitor on q confirms banks 1 and 3 stay Z. Reg1 high nibble holds its previous value.
- Write mask=0 mid-scan (during bank1 SENSE): the current scan completes all 4 banks; the next poll produces no activity and no autosend.
- Assert rst_n low during CHARGE: q goes Z the same cycle (async); after release, registers read sens=1, poll=0, mask=0x0F, results 0.
- With QTR_CHGDET_EN: two scans with identical pins give exactly one autosend; flipping q[5] on the third scan gives an autosend and reg0=0x01→0x21. Without the macro, the same stimulus gives 3 autosends.
- sens=0 and sens=255: the sample occurs at the 1st and the 255th u10clk of SENSE respectively. An m10clk during the 255-tick scan leaves pollcount unchanged.

Source files
------------

// File: rtl/qtr_pkg.sv
// Shared encodings for the QTR-RC quad-sensor scan controller:
// FSM states, bus register offsets and the lowest-set-bit helper.
package qtr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CHARGE  = 2'd1,
      ST_SENSE   = 2'd2,
      ST_ADVANCE = 2'd3
   } state_t;

   localparam logic [2:0] REG_RES_LO = 3'd0;
   localparam logic [2:0] REG_RES_HI = 3'd1;
   localparam logic [2:0] REG_SENS   = 3'd2;
   localparam logic [2:0] REG_POLL   = 3'd3;
   localparam logic [2:0] REG_MASK   = 3'd4;

   localparam logic [7:0] AUTOSEND_LEN = 8'h02;

   // Index of the lowest set bit; 0 when no bit is set.
   function automatic logic [1:0] lowest_set(input logic [3:0] m);
      logic [1:0] r;
      casez (m)
         4'b???1: r = 2'd0;
         4'b??10: r = 2'd1;
         4'b?100: r = 2'd2;
         4'b1000: r = 2'd3;
         default: r = 2'd0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/qtr_bank_sel.sv
// Finds the next enabled bank strictly above the current one in the
// latched scan mask, and flags when no such bank remains.
module qtr_bank_sel
   import qtr_pkg::*;
(
   input  logic [3:0] i_mask,
   input  logic [1:0] i_bank,
   output logic [1:0] o_next,
   output logic       o_none
);

   logic [3:0] w_above;

   assign w_above = i_mask & (4'b1110 << i_bank);
   assign o_next  = lowest_set(w_above);
   assign o_none  = (w_above == 4'd0);

endmodule

// File: rtl/qtr_scan_ctrl.sv
// Time-shared charge/sense scanner for four QTR-RC quad sensors on the peripheral bus.
// Optional macro QTR_CHGDET_EN: autosend only when the new 16-bit map differs from the previous one.
module qtr_scan_ctrl
   import qtr_pkg::*;
#(
   parameter int NBANK     = 4,
   parameter int CHG_TICKS = 1
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rdwr,
   input  logic                 strobe,
   input  logic [3:0]           our_addr,
   input  logic [11:0]          addr,
   input  logic                 busy_in,
   output logic                 busy_out,
   input  logic                 addr_match_in,
   output logic                 addr_match_out,
   input  logic [7:0]           datin,
   output logic [7:0]           datout,
   input  logic                 m10clk,
   input  logic                 u10clk,
   inout  wire  [4*NBANK-1:0]   q
);

   localparam logic [7:0] CHG_LAST = 8'(CHG_TICKS - 1);

   state_t      r_state;
   logic [3:0]  r_polltime;
   logic [7:0]  r_sens;
   logic [3:0]  r_mask;
   logic [3:0]  r_scan_mask;
   logic [15:0] r_result;
   logic [15:0] r_shadow;
   logic        r_data_avail;
   logic [3:0]  r_pollcount;
   logic [1:0]  r_bank;
   logic [7:0]  r_senscount;
   logic [7:0]  r_chgcount;

   logic        w_myaddr;
   logic        w_rd;
   logic        w_wr;
   logic [1:0]  w_next_bank;
   logic        w_none;
   logic [7:0]  w_eff_sens;
   logic [15:0] w_new_result;
   logic        w_set_avail;
   logic [4*NBANK-1:0] w_oe;
   logic [3:0]  w_bank_pins;
   logic [7:0]  w_rdata;

   assign w_myaddr       = (addr[11:8] == our_addr) && (addr[7:3] == 5'd0);
   assign w_rd           = w_myaddr && strobe && rdwr;
   assign w_wr           = w_myaddr && strobe && !rdwr;
   assign busy_out       = busy_in;
   assign addr_match_out = w_myaddr | addr_match_in;
   assign w_eff_sens     = (r_sens == 8'd0) ? 8'd1 : r_sens;
   assign w_bank_pins    = q[{r_bank, 2'b00} +: 4];

   // Only the selected bank is driven, and only while charging; state is async-reset so q floats at once.
   assign w_oe = (r_state == ST_CHARGE) ? (16'h000F << {r_bank, 2'b00}) : 16'h0000;
   for (genvar i = 0; i < 4*NBANK; i++) begin : g_pin
      assign q[i] = w_oe[i] ? 1'b1 : 1'bz;
   end

   qtr_bank_sel u_bank_sel (
      .i_mask (r_scan_mask),
      .i_bank (r_bank),
      .o_next (w_next_bank),
      .o_none (w_none)
   );

   // Merge freshly sensed nibbles of scanned banks over the held result.
   always_comb begin
      for (int b = 0; b < 4; b++) begin
         w_new_result[4*b +: 4] = r_scan_mask[b] ? r_shadow[4*b +: 4] : r_result[4*b +: 4];
      end
   end

`ifdef QTR_CHGDET_EN
   assign w_set_avail = (w_new_result != r_result);
`else
   assign w_set_avail = 1'b1;
`endif

   // Register read mux.
   always_comb begin
      case (addr[2:0])
         REG_RES_LO: w_rdata = r_result[7:0];
         REG_RES_HI: w_rdata = r_result[15:8];
         REG_SENS:   w_rdata = r_sens;
         REG_POLL:   w_rdata = {4'h0, r_polltime};
         REG_MASK:   w_rdata = {4'h0, r_mask};
         default:    w_rdata = 8'h00;
      endcase
   end

   // Bus data out: read data, then the autosend length, otherwise pass-through.
   always_comb begin
      if (w_rd) begin
         datout = w_rdata;
      end else if (w_myaddr && !strobe && r_data_avail) begin
         datout = AUTOSEND_LEN;
      end else begin
         datout = datin;
      end
   end

   // Host-writable configuration registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sens     <= 8'd1;
         r_polltime <= 4'd0;
         r_mask     <= 4'hF;
      end else if (w_wr) begin
         case (addr[2:0])
            REG_SENS: r_sens     <= datin;
            REG_POLL: r_polltime <= datin[3:0];
            REG_MASK: r_mask     <= datin[3:0];
            default:  r_sens     <= r_sens;
         endcase
      end
   end

   // Scan FSM; a scan-end set of data_avail overrides a same-cycle read clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_scan_mask  <= 4'h0;
         r_result     <= 16'h0000;
         r_shadow     <= 16'h0000;
         r_data_avail <= 1'b0;
         r_pollcount  <= 4'd1;
         r_bank       <= 2'd0;
         r_senscount  <= 8'd1;
         r_chgcount   <= 8'd0;
      end else begin
         if (w_rd) begin
            r_data_avail <= 1'b0;
         end
         case (r_state)
            ST_IDLE: begin
               if (m10clk && (r_polltime != 4'd0)) begin
                  if (r_pollcount >= r_polltime) begin
                     r_pollcount <= 4'd1;
                     if (r_mask != 4'd0) begin
                        r_scan_mask <= r_mask;
                        r_bank      <= lowest_set(r_mask);
                        r_chgcount  <= 8'd0;
                        r_state     <= ST_CHARGE;
                     end
                  end else begin
                     r_pollcount <= r_pollcount + 4'd1;
                  end
               end
            end
            ST_CHARGE: begin
               if (u10clk) begin
                  if (r_chgcount >= CHG_LAST) begin
                     r_senscount <= 8'd1;
                     r_state     <= ST_SENSE;
                  end else begin
                     r_chgcount <= r_chgcount + 8'd1;
                  end
               end
            end
            ST_SENSE: begin
               // >= keeps a mid-sense sens reduction from wrapping the counter.
               if (u10clk) begin
                  if (r_senscount >= w_eff_sens) begin
                     r_shadow[{r_bank, 2'b00} +: 4] <= w_bank_pins;
                     r_state <= ST_ADVANCE;
                  end else begin
                     r_senscount <= r_senscount + 8'd1;
                  end
               end
            end
            ST_ADVANCE: begin
               if (!w_none) begin
                  r_bank     <= w_next_bank;
                  r_chgcount <= 8'd0;
                  r_state    <= ST_CHARGE;
               end else begin
                  r_result <= w_new_result;
                  if (w_set_avail) begin
                     r_data_avail <= 1'b1;
                  end
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_qtr_scan_ctrl.sv
// Self-checking bench for qtr_scan_ctrl: table-driven bus vectors plus directed scan sequences.
module tb_qtr_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rdwr = 1'b0;
   logic        strobe = 1'b0;
   logic [3:0]  our_addr = 4'h5;
   logic [11:0] addr = 12'h500;
   logic        busy_in = 1'b0;
   logic        addr_match_in = 1'b0;
   logic [7:0]  datin = 8'h00;
   logic        m10clk = 1'b0;
   logic        u10clk = 1'b0;
   wire         busy_out;
   wire         addr_match_out;
   wire  [7:0]  datout;
   wire  [15:0] q;
   logic [15:0] pins = 16'h0000;

   // Sensor model: black pins hold the line high, white pins float low.
   for (genvar i = 0; i < 16; i++) begin : g_sensor
      assign q[i] = pins[i] ? 1'b1 : 1'bz;
   end

   qtr_scan_ctrl #(.NBANK(4), .CHG_TICKS(1)) dut (
      .clk(clk), .rst_n(rst_n), .rdwr(rdwr), .strobe(strobe), .our_addr(our_addr),
      .addr(addr), .busy_in(busy_in), .busy_out(busy_out), .addr_match_in(addr_match_in),
      .addr_match_out(addr_match_out), .datin(datin), .datout(datout),
      .m10clk(m10clk), .u10clk(u10clk), .q(q)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         repeat (3) @(negedge clk);
         u10clk = 1'b1;
         @(negedge clk);
         u10clk = 1'b0;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int total = 0;
   int bad = 0;
   int cur_bank = -1;
   int drv_cnt[4];
   int order_q[$];
   int multi = 0;

   // Drive monitor: a bank counts as driven when any of its white pins reads high.
   initial begin
      forever begin
         logic [15:0] w;
         int nb;
         int b;
         @(posedge clk);
         #1;
         w = q & ~pins;
         nb = 0;
         b = -1;
         for (int k = 0; k < 4; k++) begin
            if (|w[4*k +: 4]) begin
               nb++;
               b = k;
               drv_cnt[k]++;
            end
         end
         if (nb > 1) multi++;
         if (b != -1 && b != cur_bank) order_q.push_back(b);
         cur_bank = b;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      order_q.delete();
      multi = 0;
      for (int k = 0; k < 4; k++) drv_cnt[k] = 0;
   endtask

   function automatic int order_code();
      int c = 0;
      foreach (order_q[i]) c = (c << 4) | order_q[i];
      return (order_q.size() << 16) | c;
   endfunction

   task automatic pulse_m10();
      @(negedge clk);
      m10clk = 1'b1;
      @(negedge clk);
      m10clk = 1'b0;
   endtask

   task automatic bus_read(input logic [11:0] a, output logic [7:0] d);
      @(negedge clk);
      addr = a; rdwr = 1'b1; strobe = 1'b1; datin = 8'h00;
      #1;
      d = datout;
      @(negedge clk);
      addr = 12'h500; rdwr = 1'b0; strobe = 1'b0;
   endtask

   task automatic bus_write(input logic [11:0] a, input logic [7:0] d);
      @(negedge clk);
      addr = a; rdwr = 1'b0; strobe = 1'b1; datin = d;
      @(negedge clk);
      addr = 12'h500; strobe = 1'b0; datin = 8'h00;
   endtask

   task automatic wait_bank(input int b, input string name);
      for (int n = 0; n < 400 && cur_bank != b; n++) begin
         @(posedge clk);
         #2;
      end
      check(name, cur_bank, b);
   endtask

   task automatic wait_avail(input string name, input int maxcyc);
      bit seen = 1'b0;
      for (int n = 0; n < maxcyc && !seen; n++) begin
         @(posedge clk);
         #2;
         if (datout == 8'h02) seen = 1'b1;
      end
      check(name, int'(seen), 1);
   endtask

   task automatic no_activity(input string name, input int ncyc);
      bit seen = 1'b0;
      for (int n = 0; n < ncyc; n++) begin
         @(posedge clk);
         #2;
         if (datout == 8'h02) seen = 1'b1;
      end
      check({name, " autosend"}, int'(seen), 0);
      check({name, " drive"}, order_q.size(), 0);
   endtask

   // Count u10clk ticks from the end of bank 0 charge to the autosend.
   task automatic measure(input int exp_pulses, input bit inject, input string name);
      int pulses = 0;
      bit done = 1'b0;
      bit injected = 1'b0;
      logic [7:0] d;
      pulse_m10();
      wait_bank(0, {name, " charge"});
      wait_bank(-1, {name, " sense"});
      for (int n = 0; n < 2000 && !done; n++) begin
         @(posedge clk);
         if (u10clk) pulses++;
         #2;
         m10clk = 1'b0;
         if (inject && !injected && pulses == 100) begin
            m10clk = 1'b1;
            injected = 1'b1;
         end
         if (datout == 8'h02) done = 1'b1;
      end
      m10clk = 1'b0;
      check({name, " done"}, int'(done), 1);
      check({name, " ticks"}, pulses, exp_pulses);
      bus_read(12'h500, d);
   endtask

   task automatic scan_once(output bit sent, output logic [7:0] r0);
      clear_mon();
      pulse_m10();
      wait_bank(3, "chg bank3");
      wait_bank(-1, "chg end");
      sent = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk);
         #2;
         if (datout == 8'h02) sent = 1'b1;
      end
      bus_read(12'h500, r0);
   endtask

   typedef struct {
      bit          wr;
      logic [11:0] a;
      logic [7:0]  din;
      logic        bsy;
      logic [7:0]  dout;
      logic        match;
   } vec_t;

`ifdef QTR_CHGDET_EN
   localparam int EXP_SENDS = 2;
   localparam int EXP_SEND2 = 0;
`else
   localparam int EXP_SENDS = 3;
   localparam int EXP_SEND2 = 1;
`endif

   initial begin
      vec_t vt[19];
      logic [7:0] d;
      bit s;
      int sends;

      vt[0]  = '{1'b0, 12'h500, 8'h00, 1'b0, 8'h00, 1'b1};
      vt[1]  = '{1'b0, 12'h501, 8'h00, 1'b1, 8'h00, 1'b1};
      vt[2]  = '{1'b0, 12'h502, 8'h00, 1'b0, 8'h01, 1'b1};
      vt[3]  = '{1'b0, 12'h503, 8'h00, 1'b1, 8'h00, 1'b1};
      vt[4]  = '{1'b0, 12'h504, 8'h00, 1'b0, 8'h0F, 1'b1};
      vt[5]  = '{1'b0, 12'h505, 8'h00, 1'b0, 8'h00, 1'b1};
      vt[6]  = '{1'b0, 12'h507, 8'h00, 1'b1, 8'h00, 1'b1};
      vt[7]  = '{1'b1, 12'h502, 8'h03, 1'b0, 8'h03, 1'b1};
      vt[8]  = '{1'b0, 12'h502, 8'h00, 1'b0, 8'h03, 1'b1};
      vt[9]  = '{1'b1, 12'h504, 8'hA5, 1'b1, 8'hA5, 1'b1};
      vt[10] = '{1'b0, 12'h504, 8'h00, 1'b0, 8'h05, 1'b1};
      vt[11] = '{1'b1, 12'h503, 8'h31, 1'b0, 8'h31, 1'b1};
      vt[12] = '{1'b0, 12'h503, 8'h00, 1'b0, 8'h01, 1'b1};
      vt[13] = '{1'b1, 12'h500, 8'hFF, 1'b0, 8'hFF, 1'b1};
      vt[14] = '{1'b0, 12'h500, 8'h00, 1'b1, 8'h00, 1'b1};
      vt[15] = '{1'b0, 12'h608, 8'h77, 1'b0, 8'h77, 1'b0};
      vt[16] = '{1'b0, 12'h508, 8'h3C, 1'b0, 8'h3C, 1'b0};
      vt[17] = '{1'b1, 12'h504, 8'h0F, 1'b0, 8'h0F, 1'b1};
      vt[18] = '{1'b0, 12'h504, 8'h00, 1'b0, 8'h0F, 1'b1};

      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Register map, address decode and pass-through.
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         addr = vt[i].a; rdwr = !vt[i].wr; datin = vt[i].din; busy_in = vt[i].bsy; strobe = 1'b1;
         #1;
         check($sformatf("vec%0d datout", i), datout, vt[i].dout);
         check($sformatf("vec%0d match", i), addr_match_out, vt[i].match);
         check($sformatf("vec%0d busy", i), busy_out, vt[i].bsy);
      end
      @(negedge clk);
      strobe = 1'b0; rdwr = 1'b0; addr = 12'h500; datin = 8'h00; busy_in = 1'b0;

      // Full 4-bank scan, sens=3, polltime=1.
      pins = 16'h8421;
      clear_mon();
      pulse_m10();
      wait_avail("A autosend", 400);
      check("A order", order_code(), (4 << 16) | 16'h0123);
      check("A overlap", multi, 0);
      bus_read(12'h500, d);
      check("A reg0", d, 8'h21);
      bus_read(12'h501, d);
      check("A reg1", d, 8'h84);
      #1;
      check("A avail cleared", datout, 8'h00);

      // Banks 0 and 2 only; banks 1 and 3 keep old results.
      bus_write(12'h504, 8'h05);
      pins = 16'h0000;
      clear_mon();
      pulse_m10();
      wait_avail("B autosend", 400);
      check("B order", order_code(), (2 << 16) | 16'h0002);
      check("B bank1 idle", drv_cnt[1], 0);
      check("B bank3 idle", drv_cnt[3], 0);
      bus_read(12'h500, d);
      check("B reg0", d, 8'h20);
      bus_read(12'h501, d);
      check("B reg1", d, 8'h80);

      // mask=0 written during bank1 sense: scan still finishes, next poll is silent.
      bus_write(12'h504, 8'h0F);
      pins = 16'h8421;
      clear_mon();
      pulse_m10();
      wait_bank(1, "C bank1");
      wait_bank(-1, "C bank1 sense");
      bus_write(12'h504, 8'h00);
      wait_avail("C autosend", 400);
      check("C order", order_code(), (4 << 16) | 16'h0123);
      bus_read(12'h500, d);
      check("C reg0", d, 8'h21);
      clear_mon();
      pulse_m10();
      no_activity("C mask0", 40);

      // Sample timing for sens 3, 0 and 255.
      bus_write(12'h504, 8'h01);
      measure(3, 1'b0, "sens3");
      bus_write(12'h502, 8'h00);
      measure(1, 1'b0, "sens0");
      bus_write(12'h502, 8'hFF);
      bus_write(12'h503, 8'h02);
      clear_mon();
      pulse_m10();
      no_activity("poll2 first", 20);
      measure(255, 1'b1, "sens255");
      // pollcount must have stayed frozen through the mid-scan m10clk.
      clear_mon();
      pulse_m10();
      no_activity("frozen", 20);
      pulse_m10();
      wait_bank(0, "D rescan");

      // Async reset during CHARGE.
      check("E driven", int'(q[3:1]), 3'b111);
      rst_n = 1'b0;
      #1;
      check("E q float", int'(q & ~pins), 0);
      @(negedge clk);
      rst_n = 1'b1;
      bus_read(12'h502, d);
      check("E sens", d, 8'h01);
      bus_read(12'h503, d);
      check("E poll", d, 8'h00);
      bus_read(12'h504, d);
      check("E mask", d, 8'h0F);
      bus_read(12'h500, d);
      check("E res lo", d, 8'h00);
      bus_read(12'h501, d);
      check("E res hi", d, 8'h00);

      // Change detect: identical scans, then q[5] flipped.
      bus_write(12'h503, 8'h01);
      pins = 16'h8401;
      sends = 0;
      scan_once(s, d);
      sends += int'(s);
      check("F scan1 sent", int'(s), 1);
      check("F scan1 reg0", d, 8'h01);
      scan_once(s, d);
      sends += int'(s);
      check("F scan2 sent", int'(s), EXP_SEND2);
      pins = 16'h8421;
      scan_once(s, d);
      sends += int'(s);
      check("F scan3 sent", int'(s), 1);
      check("F scan3 reg0", d, 8'h21);
      check("F sends", sends, EXP_SENDS);
      bus_read(12'h501, d);
      check("F reg1", d, 8'h84);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
